// File: rtl/decoder_scan_n_pkg.sv
// Shared definitions for the scanning one-hot decoder: FSM state encoding,
// counter sizing and the one-hot helper.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_DWELL  = 2'd2,
    ST_BLANK  = 2'd3
  } state_e;

  // Counter is never narrower than one bit, even for DWELL=1 / BLANK=0.
  function automatic int unsigned cnt_width(input int unsigned dwell, input int unsigned blank);
    int unsigned m;
    m = 2;
    if (dwell > m) m = dwell;
    if (blank > m) m = blank;
    return $clog2(m);
  endfunction

  function automatic logic [31:0] onehot(input int i);
    return 32'd1 << i;
  endfunction

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control and output bundle of the scanning decoder; the slave side is the decoder.
interface decoder_scan_n_if #(
  parameter int unsigned SEL_W = 2
);
  localparam int unsigned N = 1 << SEL_W;

  logic             en;
  logic             scan;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     z;
  logic             en_out;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (output en, output scan, output sel,
                  input z, input en_out, input idx, input wrap);
  modport slave  (input en, input scan, input sel,
                  output z, output en_out, output idx, output wrap);
endinterface

// File: rtl/decoder_scan_n_onehot_dec.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder; all zeros when disabled.
module onehot_dec
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]      idx_i,
  input  logic                  en_i,
  output logic [(1<<SEL_W)-1:0] dec_o
);
  localparam int unsigned N = 1 << SEL_W;

  assign dec_o = en_i ? N'(onehot(int'(idx_i))) : '0;

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with direct mode and autonomous dwell/blank scan.
// States: OFF (disabled) | DIRECT (z = onehot(sel)) | DWELL (hold idx) | BLANK (all inactive)
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned DWELL      = 4,
  parameter int unsigned BLANK      = 1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  decoder_scan_n_if.slave bus
);
  localparam int unsigned N     = 1 << SEL_W;
  localparam int unsigned CNT_W = cnt_width(DWELL, BLANK);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d, idx_inc;
  logic [N-1:0]     z_q, z_d, dec;
  logic             en_out_q, en_out_d;
  logic             wrap_q, wrap_d;
  logic             dec_en;

  assign idx_inc = idx_q + SEL_W'(1);

  always_comb begin
    state_d  = ST_OFF;
    cnt_d    = '0;
    idx_d    = '0;
    en_out_d = 1'b0;
    wrap_d   = 1'b0;
    if (bus.en) begin
      en_out_d = 1'b1;
      if (!bus.scan) begin
        state_d = ST_DIRECT;
        idx_d   = bus.sel;
      end else begin
        // Entering from DIRECT keeps the last sel; from OFF idx_q is already 0.
        state_d = ST_DWELL;
        idx_d   = idx_q;
        unique case (state_q)
          ST_OFF:    idx_d = '0;
          ST_DIRECT: ;
          ST_DWELL: begin
            if (cnt_q == DWELL_LAST) begin
              if (BLANK > 0) begin
                state_d = ST_BLANK;
              end else begin
                idx_d  = idx_inc;
                wrap_d = (idx_inc == '0);
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              idx_d  = idx_inc;
              wrap_d = (idx_inc == '0);
            end else begin
              state_d = ST_BLANK;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dec_en = (state_d == ST_DIRECT) || (state_d == ST_DWELL);

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx_i (idx_d),
    .en_i  (dec_en),
    .dec_o (dec)
  );

  assign z_d = dec ^ {N{ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      idx_q    <= '0;
      z_q      <= {N{ACTIVE_LOW}};
      en_out_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      z_q      <= z_d;
      en_out_q <= en_out_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.z      = z_q;
  assign bus.en_out = en_out_q;
  assign bus.idx    = idx_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: doc/decoder_scan_n.md
# decoder_scan_n

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable, extended with an autonomous scan mode for time-multiplexed loads (7-segment digit selects, LED matrix rows). In direct mode it decodes `sel` like the earlier 2-to-4 encoders, but through an output register. In scan mode it walks the outputs itself, with a programmable dwell and anti-ghosting blank interval. It sits between board-level control logic and the multiplexed display or row drivers.

## Interface
- SEL_W, 2: select width; output width N = 2^SEL_W; range 1..5.
- DWELL, 4: cycles each output is held active in scan mode; must be ≥1.
- BLANK, 1: all-inactive cycles between scan steps; 0 disables blanking.
- ACTIVE_LOW, 0: 1 inverts `z` (inactive = all ones).
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable.
- scan  input  1  0 = direct decode of `sel`; 1 = autonomous scan.
- sel  input  SEL_W  direct-mode index; ignored in scan mode.
- z  output  N  registered one-hot outputs, polarity per ACTIVE_LOW.
- en_out  output  1  registered; 1 whenever the block was enabled in the previous cycle.
- idx  output  SEL_W  index currently (or last) driven.
- wrap  output  1  one-cycle pulse when scan idx wraps from N-1 to 0.

## Operation
- Reset values: z inactive (0s, or 1s if ACTIVE_LOW), en_out 0, idx 0, wrap 0, state OFF, dwell/blank counter 0.
- States: OFF, DIRECT, DWELL, BLANK.
- OFF: entered whenever en=0, from any state.
  - z inactive, en_out 0, idx 0, counter 0, wrap 0.
  - en always takes priority over scan and sel.
- DIRECT (en=1, scan=0):
  - z = onehot(sel), idx = sel, en_out 1, wrap 0.
  - sel may change every cycle.
- DWELL (en=1, scan=1):
  - z = onehot(idx); counter counts 0..DWELL-1.
  - At DWELL-1 the counter clears. If BLANK>0, go to BLANK. If BLANK=0, idx increments mod N and DWELL continues.
- BLANK:
  - z inactive, en_out 1; counter counts 0..BLANK-1.
  - Then idx increments mod N and the state returns to DWELL.
- wrap asserts in the same cycle that idx becomes 0 through a scan increment. It never asserts on reset, OFF, or DIRECT.
- Mode change DIRECT→scan: enter DWELL at the current idx (the last sel), counter cleared.
- Mode change scan→DIRECT: next cycle is DIRECT; counter cleared; any remaining dwell/blank is abandoned.
- OFF→scan: starts at idx 0, DWELL.
- Counter width: $clog2 of max(DWELL, BLANK, 2). No arithmetic overflow is possible. idx wrap is natural SEL_W-bit modulo.
- N=2 (SEL_W=1) is legal and must behave identically to larger N.

## Timing
- All outputs are registered. Inputs sampled at edge k appear on outputs after edge k (one-cycle latency), including en→en_out.
- Scan step period: DWELL+BLANK cycles. Full frame: N×(DWELL+BLANK) cycles. Each output is active exactly DWELL consecutive cycles per frame.
- At most one output is active in any cycle. Two outputs are never active in the same or adjacent cycles when BLANK≥1.
- rst asserted mid-scan: the next edge yields the reset values regardless of en/scan. Scan restarts at idx 0 on the first enabled cycle after release.

## Structure
- Shared package `decoder_pkg`:
  - state encoding constants ST_OFF, ST_DIRECT, ST_DWELL, ST_BLANK;
  - a `onehot` width-generic function/constant helper.
- One sub-module is natural: `onehot_dec`, a combinational SEL_W→N decoder with enable.
  - Instantiated once, feeding the z register.
  - Polarity inversion applied at the register input.

## Test plan
- Reset + direct, SEL_W=2: rst 2 cycles, then en=1, scan=0, sel=2 → z=4'b0000 during reset; z=4'b0100, en_out=1, idx=2 one cycle after the first enabled edge.
- Enable gating: direct mode, en dropped for 1 cycle with sel=3 → z=0000, en_out=0 next cycle; z=1000 resumes one cycle after en returns.
- Scan, DWELL=4, BLANK=1, SEL_W=2: from OFF, set en=1, scan=1 → z sequence 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, 0001. wrap is high exactly on the first cycle of the second 0001. The frame is 20 cycles.
- BLANK=0, ACTIVE_LOW=1, SEL_W=3, DWELL=1 → z walks 11111110, 11111101, … with a one-cycle step and no all-ones gaps; wrap every 8 cycles.
- Mid-operation events:
  - scan→direct in cycle 2 of a dwell with sel=1 → z=0010 next cycle.
  - direct→scan → dwell restarts at idx 1 for the full DWELL.
  - rst mid-BLANK → reset values next cycle; scan restarts at idx 0.
